code_stream_scheduler: RTL and testbench

CODE_STREAM_SCHEDULER -- requirements
Module: code_stream_scheduler

---
 rtl/code_stream_scheduler.sv | 168 ++++++++++++++++
 tb/tb_code_stream_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/code_stream_scheduler.sv
// Interleaves per-channel entropy-code streams block by block into one packer stream,
// inserting RSTn markers every restart_interval MCUs.
module code_stream_scheduler #(
   parameter int unsigned ROW        = 3,
   parameter int unsigned CODE_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 6
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [15:0]                         mcus_per_frame,
   input  logic [15:0]                         restart_interval,
   input  logic [ROW-1:0]                      in_valid,
   input  logic [ROW-1:0][CODE_WIDTH-1:0]      in_code,
   input  logic [ROW-1:0][LEN_WIDTH-1:0]       in_len,
   input  logic [ROW-1:0]                      in_eob,
   output logic [ROW-1:0]                      in_ready,
   output logic                                out_valid,
   output logic [CODE_WIDTH-1:0]               out_code,
   output logic [LEN_WIDTH-1:0]                out_len,
   output logic [1:0]                          out_chan,
   output logic                                out_marker,
   input  logic                                out_ready,
   output logic                                busy,
   output logic                                done
);

   typedef enum logic [1:0] {StIdle, StServe, StMarker} state_e;

   localparam logic [1:0] LastCh = 2'(ROW - 1);

   state_e                 state_q, state_d;
   logic [1:0]             grant_q, grant_d;
   logic [15:0]            mcu_cnt_q, mcu_cnt_d;
   logic [15:0]            rst_cnt_q, rst_cnt_d;
   logic [2:0]             rst_idx_q, rst_idx_d;
   logic [15:0]            mpf_q, mpf_d;
   logic [15:0]            ri_q, ri_d;
   logic                   out_valid_q, out_valid_d;
   logic [CODE_WIDTH-1:0]  out_code_q, out_code_d;
   logic [LEN_WIDTH-1:0]   out_len_q, out_len_d;
   logic [1:0]             out_chan_q, out_chan_d;
   logic                   out_marker_q, out_marker_d;
   logic                   done_q, done_d;
   logic                   load;
   logic [15:0]            mcu_next, rst_next;

   assign load     = !out_valid_q || out_ready;
   assign mcu_next = mcu_cnt_q + 16'd1;
   assign rst_next = rst_cnt_q + 16'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         mcu_cnt_q    <= '0;
         rst_cnt_q    <= '0;
         rst_idx_q    <= '0;
         mpf_q        <= '0;
         ri_q         <= '0;
         out_valid_q  <= 1'b0;
         out_code_q   <= '0;
         out_len_q    <= '0;
         out_chan_q   <= '0;
         out_marker_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         mcu_cnt_q    <= mcu_cnt_d;
         rst_cnt_q    <= rst_cnt_d;
         rst_idx_q    <= rst_idx_d;
         mpf_q        <= mpf_d;
         ri_q         <= ri_d;
         out_valid_q  <= out_valid_d;
         out_code_q   <= out_code_d;
         out_len_q    <= out_len_d;
         out_chan_q   <= out_chan_d;
         out_marker_q <= out_marker_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      mcu_cnt_d    = mcu_cnt_q;
      rst_cnt_d    = rst_cnt_q;
      rst_idx_d    = rst_idx_q;
      mpf_d        = mpf_q;
      ri_d         = ri_q;
      out_valid_d  = out_valid_q;
      out_code_d   = out_code_q;
      out_len_d    = out_len_q;
      out_chan_d   = out_chan_q;
      out_marker_d = out_marker_q;
      done_d       = 1'b0;
      // A free or draining output register empties unless refilled below.
      if (load) out_valid_d = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StServe;
               grant_d   = '0;
               mcu_cnt_d = '0;
               rst_cnt_d = '0;
               rst_idx_d = '0;
               mpf_d     = (mcus_per_frame == 16'd0) ? 16'd1 : mcus_per_frame;
               ri_d      = restart_interval;
            end
         end
         StServe: begin
            if (load && in_valid[grant_q]) begin
               out_valid_d  = 1'b1;
               out_code_d   = in_code[grant_q];
               out_len_d    = in_len[grant_q];
               out_chan_d   = grant_q;
               out_marker_d = 1'b0;
               if (in_eob[grant_q]) begin
                  if (grant_q == LastCh) begin
                     grant_d   = '0;
                     mcu_cnt_d = mcu_next;
                     rst_cnt_d = rst_next;
                     // Frame end wins over a coincident restart interval.
                     if (mcu_next >= mpf_q) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                     end else if (ri_q != 16'd0 && rst_next == ri_q) begin
                        state_d = StMarker;
                     end
                  end else begin
                     grant_d = grant_q + 2'd1;
                  end
               end
            end
         end
         StMarker: begin
            if (load) begin
               out_valid_d  = 1'b1;
               out_code_d   = CODE_WIDTH'(16'hFFD0 | {13'd0, rst_idx_q});
               out_len_d    = LEN_WIDTH'(16);
               out_chan_d   = 2'd0;
               out_marker_d = 1'b1;
               rst_idx_d    = rst_idx_q + 3'd1;
               rst_cnt_d    = '0;
               state_d      = StServe;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready = '0;
      for (int i = 0; i < int'(ROW); i++) begin
         if (!rst && state_q == StServe && grant_q == 2'(i) && load) in_ready[i] = 1'b1;
      end
   end

   assign out_valid  = out_valid_q & ~rst;
   assign out_code   = rst ? '0 : out_code_q;
   assign out_len    = rst ? '0 : out_len_q;
   assign out_chan   = rst ? '0 : out_chan_q;
   assign out_marker = out_marker_q & ~rst;
   assign busy       = (state_q != StIdle) & ~rst;
   assign done       = done_q & ~rst;

endmodule

// File: tb/tb_code_stream_scheduler.sv
// Self-checking bench: table-driven frame configs, randomized frames against a
// block/MCU-level reference model, plus reset-abort and stray-start sequences.
module tb_code_stream_scheduler;
   localparam int ROW = 3;
   localparam int CW  = 32;
   localparam int LW  = 6;

   logic                   clk = 1'b0;
   logic                   rst, start, out_ready;
   logic [15:0]            mcus_per_frame, restart_interval;
   logic [ROW-1:0]         in_valid, in_eob, in_ready;
   logic [ROW-1:0][CW-1:0] in_code;
   logic [ROW-1:0][LW-1:0] in_len;
   logic                   out_valid, out_marker, busy, done;
   logic [CW-1:0]          out_code;
   logic [LW-1:0]          out_len;
   logic [1:0]             out_chan;

   always #5 clk = ~clk;

   code_stream_scheduler #(.ROW(ROW), .CODE_WIDTH(CW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .mcus_per_frame(mcus_per_frame),
      .restart_interval(restart_interval), .in_valid(in_valid), .in_code(in_code),
      .in_len(in_len), .in_eob(in_eob), .in_ready(in_ready), .out_valid(out_valid),
      .out_code(out_code), .out_len(out_len), .out_chan(out_chan), .out_marker(out_marker),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   typedef struct { logic [31:0] code; logic [5:0] len; logic eob; } src_t;
   typedef struct { logic [31:0] code; logic [5:0] len; logic [1:0] chan; logic marker; } word_t;
   typedef struct { int mpf; int ri; int mode; int wpb; int stray; int exp_words; int exp_markers; } vec_t;

   src_t  srcq[ROW][$];
   word_t expq[$];
   word_t gotq[$];
   int    exp_ch[$];
   int    errors = 0;
   int    checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: blocks in MCU-major, channel-minor order; a marker after every
   // restart_interval-th MCU except the last, index wrapping mod 8.
   task automatic build_model(input int mpf, input int ri, input int wpb);
      int eff, idx, n;
      src_t s;
      for (int c = 0; c < ROW; c++) srcq[c].delete();
      expq.delete();
      exp_ch.delete();
      eff = (mpf == 0) ? 1 : mpf;
      idx = 0;
      for (int m = 0; m < eff; m++) begin
         for (int c = 0; c < ROW; c++) begin
            n = (wpb != 0) ? wpb : int'($urandom_range(1, 3));
            for (int w = 0; w < n; w++) begin
               s.code = $urandom;
               s.len  = 6'($urandom_range(1, 32));
               s.eob  = (w == n - 1);
               srcq[c].push_back(s);
               expq.push_back('{s.code, s.len, 2'(c), 1'b0});
               exp_ch.push_back(c);
            end
         end
         if (ri != 0 && (m + 1) % ri == 0 && m + 1 < eff) begin
            expq.push_back('{32'hFFD0 + 32'(idx % 8), 6'd16, 2'd0, 1'b1});
            idx++;
         end
      end
   endtask

   task automatic run_frame(input int mpf, input int ri, input int mode, input int wpb,
                            input int stray, input int abort, output int ndone);
      int    acc_idx, finished;
      logic  prev_stall, out_acc;
      logic [ROW-1:0] in_acc;
      word_t cur, prev;
      build_model(mpf, ri, wpb);
      gotq.delete();
      acc_idx  = 0;
      ndone    = 0;
      finished = 0;
      prev_stall = 1'b0;
      @(negedge clk);
      mcus_per_frame   = 16'(mpf);
      restart_interval = 16'(ri);
      start = 1'b1;
      @(posedge clk);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         start = (stray != 0 && cyc == 5);
         if (start) begin
            mcus_per_frame   = 16'd7;
            restart_interval = 16'd1;
         end
         if (cyc == 0) chk("busy_after_start", 64'(busy), 64'd1);
         if (done) ndone++;
         if (prev_stall)
            chk("stall_hold", {out_valid, out_code, out_len, out_chan, out_marker},
                {1'b1, prev.code, prev.len, prev.chan, prev.marker});
         if (ndone > 0 && !out_valid && !done) begin
            finished = 1;
            break;
         end
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0)
                   : ($urandom_range(0, 3) != 0);
         for (int c = 0; c < ROW; c++) begin
            in_valid[c] = (srcq[c].size() > 0) && (mode == 0 || $urandom_range(0, 3) != 0);
            in_code[c]  = (srcq[c].size() > 0) ? srcq[c][0].code : '0;
            in_len[c]   = (srcq[c].size() > 0) ? srcq[c][0].len  : '0;
            in_eob[c]   = (srcq[c].size() > 0) ? srcq[c][0].eob  : 1'b0;
         end
         #1;
         if (in_ready != '0) begin
            if (acc_idx < exp_ch.size()) chk("grant", 64'(in_ready), 64'(3'b001 << exp_ch[acc_idx]));
            else chk("grant_extra", 64'(in_ready), 64'd0);
         end
         if (abort != 0 && in_ready[1]) begin
            rst = 1'b1;
            break;
         end
         in_acc     = in_valid & in_ready;
         out_acc    = out_valid && out_ready;
         prev_stall = out_valid && !out_ready;
         cur        = '{out_code, out_len, out_chan, out_marker};
         prev       = cur;
         @(posedge clk);
         for (int c = 0; c < ROW; c++) begin
            if (in_acc[c]) begin
               void'(srcq[c].pop_front());
               acc_idx++;
            end
         end
         if (out_acc) gotq.push_back(cur);
      end
      start = 1'b0;
      if (abort != 0) begin
         @(negedge clk);
         in_valid = '0;
         chk("rst_outputs_zero", {out_valid, in_ready, busy, done, out_code, out_len, out_chan,
             out_marker}, 64'd0);
         @(negedge clk);
         rst = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_done_after_abort", {done, busy, out_valid}, 64'd0);
         end
         return;
      end
      in_valid = '0;
      if (finished == 0) begin
         checks++;
         errors++;
         $display("FAIL frame_timeout: got no completion expected done within budget");
      end
      chk("idle_after_frame", 64'(busy), 64'd0);
      chk("word_count", 64'(gotq.size()), 64'(expq.size()));
      for (int i = 0; i < gotq.size() && i < expq.size(); i++)
         chk($sformatf("word[%0d]", i), {gotq[i].code, gotq[i].len, gotq[i].chan, gotq[i].marker},
             {expq[i].code, expq[i].len, expq[i].chan, expq[i].marker});
   endtask

   vec_t vecs[6];
   int   nd, nm;

   initial begin
      vecs[0] = '{2, 0, 0, 3, 0, 18, 0};
      vecs[1] = '{3, 1, 0, 1, 0, 11, 2};
      vecs[2] = '{10, 1, 1, 1, 0, 39, 9};
      vecs[3] = '{0, 0, 0, 2, 0, 6, 0};
      vecs[4] = '{4, 2, 2, 2, 1, 25, 1};
      vecs[5] = '{3, 3, 1, 1, 0, 9, 0};

      rst = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      in_valid = '0;
      in_code = '0;
      in_len = '0;
      in_eob = '0;
      mcus_per_frame = '0;
      restart_interval = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = '1;
      #1;
      chk("reset_outputs", {out_valid, in_ready, busy, done, out_code, out_len, out_chan,
          out_marker}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = '0;
      @(negedge clk);
      chk("idle_after_reset", {busy, out_valid, done, in_ready}, 64'd0);

      foreach (vecs[v]) begin
         run_frame(vecs[v].mpf, vecs[v].ri, vecs[v].mode, vecs[v].wpb, vecs[v].stray, 0, nd);
         chk($sformatf("done_count[%0d]", v), 64'(nd), 64'd1);
         chk($sformatf("table_words[%0d]", v), 64'(gotq.size()), 64'(vecs[v].exp_words));
         nm = 0;
         foreach (gotq[i]) if (gotq[i].marker) nm++;
         chk($sformatf("table_markers[%0d]", v), 64'(nm), 64'(vecs[v].exp_markers));
      end

      // Abort during ch1 of MCU0, then a fresh frame must restart at ch0 and marker D0.
      run_frame(2, 1, 0, 3, 0, 1, nd);
      chk("abort_no_done", 64'(nd), 64'd0);
      run_frame(2, 1, 0, 2, 0, 0, nd);
      chk("restart_done", 64'(nd), 64'd1);

      for (int r = 0; r < 6; r++) begin
         run_frame(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)), 2, 0, r % 2, 0, nd);
         chk($sformatf("rand_done[%0d]", r), 64'(nd), 64'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
